sram_dual_master_arbiter: RTL and testbench

//  Shares the single-port on-chip SRAM (1024 x 32, byte enables, registered address, unregistered q)

---
 rtl/sram_dual_master_arbiter.sv | 100 ++++++++++
 tb/tb_sram_dual_master_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_dual_master_arbiter.sv
// rtl/sram_dual_master_arbiter.sv - two Avalon-MM masters sharing one single-port SRAM
module sram_dual_master_arbiter #(
    parameter int   ADDR_W   = 10,
    parameter int   DATA_W   = 32,
    localparam int  BE_W     = DATA_W / 8,
    parameter int   ARB_MODE = 0
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,

    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,

    output logic [ADDR_W-1:0] sram_address,
    output logic [BE_W-1:0]   sram_byteenable,
    output logic              sram_chipselect,
    output logic              sram_write,
    output logic [DATA_W-1:0] sram_writedata,
    input  logic [DATA_W-1:0] sram_readdata
);

    logic req0, req1;
    logic grant0, grant1;
    logic rr_last;   // 1 = m1 was granted last, so m0 wins the next tie
    logic rd_vld;
    logic rd_owner;  // 1 = pending read data belongs to m1
    logic rd_accept;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    // Pick at most one master per cycle; nothing is granted while reset is held
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (reset_n) begin
            if (ARB_MODE == 1) begin
                grant0 = req0;
                grant1 = req1 & ~req0;
            end else begin
                grant1 = req1 & (~req0 | ~rr_last);
                grant0 = req0 & ~grant1;
            end
        end
    end

    assign m0_waitrequest = ~reset_n | (req0 & ~grant0);
    assign m1_waitrequest = ~reset_n | (req1 & ~grant1);

    // With no grant the m0 request passes through as don't-care; only chipselect/write matter
    assign sram_address    = grant1 ? m1_address    : m0_address;
    assign sram_byteenable = grant1 ? m1_byteenable : m0_byteenable;
    assign sram_writedata  = grant1 ? m1_writedata  : m0_writedata;
    assign sram_chipselect = grant0 | grant1;
    assign sram_write      = (grant0 & m0_write) | (grant1 & m1_write);

    // Read+write from one master is a write; the read half never produces data
    assign rd_accept = (grant0 & m0_read & ~m0_write) | (grant1 & m1_read & ~m1_write);

    // Round-robin history and the one-deep read return pipeline
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_last  <= 1'b1;
            rd_vld   <= 1'b0;
            rd_owner <= 1'b0;
        end else begin
            if (grant0) begin
                rr_last <= 1'b0;
            end else if (grant1) begin
                rr_last <= 1'b1;
            end
            rd_vld   <= rd_accept;
            rd_owner <= grant1;
        end
    end

    assign m0_readdatavalid = rd_vld & ~rd_owner;
    assign m1_readdatavalid = rd_vld &  rd_owner;
    assign m0_readdata      = sram_readdata;
    assign m1_readdata      = sram_readdata;

    a_m0_rd_wr_exclusive: assert property (@(posedge clk) disable iff (!reset_n) !(m0_read && m0_write));
    a_m1_rd_wr_exclusive: assert property (@(posedge clk) disable iff (!reset_n) !(m1_read && m1_write));

endmodule

// File: tb/tb_sram_dual_master_arbiter.sv
// tb/tb_sram_dual_master_arbiter.sv - bench for sram_dual_master_arbiter
module tb_sram_dual_master_arbiter;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int failed = 0;

    // DUT a: round-robin
    logic [9:0]  a_m0_addr, a_m1_addr, a_sram_addr;
    logic [3:0]  a_m0_be, a_m1_be, a_sram_be;
    logic        a_m0_rd, a_m0_wr, a_m1_rd, a_m1_wr;
    logic [31:0] a_m0_wd, a_m1_wd, a_sram_wd, a_sram_rd;
    logic        a_m0_wait, a_m1_wait, a_m0_v, a_m1_v, a_cs, a_sw;
    logic [31:0] a_m0_rdata, a_m1_rdata;

    // DUT b: fixed priority
    logic [9:0]  b_m0_addr, b_m1_addr, b_sram_addr;
    logic [3:0]  b_m0_be, b_m1_be, b_sram_be;
    logic        b_m0_rd, b_m0_wr, b_m1_rd, b_m1_wr;
    logic [31:0] b_m0_wd, b_m1_wd, b_sram_wd, b_sram_rd;
    logic        b_m0_wait, b_m1_wait, b_m0_v, b_m1_v, b_cs, b_sw;
    logic [31:0] b_m0_rdata, b_m1_rdata;

    sram_dual_master_arbiter #(.ADDR_W(10), .DATA_W(32), .ARB_MODE(0)) dut_a (
        .clk(clk), .reset_n(reset_n),
        .m0_address(a_m0_addr), .m0_byteenable(a_m0_be), .m0_read(a_m0_rd), .m0_write(a_m0_wr),
        .m0_writedata(a_m0_wd), .m0_waitrequest(a_m0_wait), .m0_readdata(a_m0_rdata),
        .m0_readdatavalid(a_m0_v),
        .m1_address(a_m1_addr), .m1_byteenable(a_m1_be), .m1_read(a_m1_rd), .m1_write(a_m1_wr),
        .m1_writedata(a_m1_wd), .m1_waitrequest(a_m1_wait), .m1_readdata(a_m1_rdata),
        .m1_readdatavalid(a_m1_v),
        .sram_address(a_sram_addr), .sram_byteenable(a_sram_be), .sram_chipselect(a_cs),
        .sram_write(a_sw), .sram_writedata(a_sram_wd), .sram_readdata(a_sram_rd)
    );

    sram_dual_master_arbiter #(.ADDR_W(10), .DATA_W(32), .ARB_MODE(1)) dut_b (
        .clk(clk), .reset_n(reset_n),
        .m0_address(b_m0_addr), .m0_byteenable(b_m0_be), .m0_read(b_m0_rd), .m0_write(b_m0_wr),
        .m0_writedata(b_m0_wd), .m0_waitrequest(b_m0_wait), .m0_readdata(b_m0_rdata),
        .m0_readdatavalid(b_m0_v),
        .m1_address(b_m1_addr), .m1_byteenable(b_m1_be), .m1_read(b_m1_rd), .m1_write(b_m1_wr),
        .m1_writedata(b_m1_wd), .m1_waitrequest(b_m1_wait), .m1_readdata(b_m1_rdata),
        .m1_readdatavalid(b_m1_v),
        .sram_address(b_sram_addr), .sram_byteenable(b_sram_be), .sram_chipselect(b_cs),
        .sram_write(b_sw), .sram_writedata(b_sram_wd), .sram_readdata(b_sram_rd)
    );

    // SRAM models: registered address, unregistered q, byte-enabled writes, preloaded pattern
    logic [31:0] mem_a [1024];
    logic [31:0] mem_b [1024];
    logic [9:0]  addr_qa = 10'd0;
    logic [9:0]  addr_qb = 10'd0;
    logic        mem_ready = 1'b0;

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 1024; i++) begin
                mem_a[i] <= 32'hA500_0000 | i;
                mem_b[i] <= 32'hA500_0000 | i;
            end
            mem_ready <= 1'b1;
        end else begin
            if (a_cs) begin
                addr_qa <= a_sram_addr;
                if (a_sw)
                    for (int k = 0; k < 4; k++)
                        if (a_sram_be[k]) mem_a[a_sram_addr][8*k +: 8] <= a_sram_wd[8*k +: 8];
            end
            if (b_cs) begin
                addr_qb <= b_sram_addr;
                if (b_sw)
                    for (int k = 0; k < 4; k++)
                        if (b_sram_be[k]) mem_b[b_sram_addr][8*k +: 8] <= b_sram_wd[8*k +: 8];
            end
        end
    end
    assign a_sram_rd = mem_a[addr_qa];
    assign b_sram_rd = mem_b[addr_qb];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Vector: inputs for one cycle of DUT a, expected {wait0,wait1,rdv0,rdv1,cs,sw} and read data
    typedef struct {
        logic        r0, w0;
        logic [9:0]  a0;
        logic [3:0]  be0;
        logic [31:0] d0;
        logic        r1, w1;
        logic [9:0]  a1;
        logic [3:0]  be1;
        logic [31:0] d1;
        logic [5:0]  exp;
        logic [31:0] edata;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r0, input logic w0, input logic [9:0] a0,
                                input logic [3:0] be0, input logic [31:0] d0,
                                input logic r1, input logic w1, input logic [9:0] a1,
                                input logic [3:0] be1, input logic [31:0] d1,
                                input logic [5:0] exp, input logic [31:0] edata);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.a0 = a0; v.be0 = be0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.be1 = be1; v.d1 = d1;
        v.exp = exp; v.edata = edata;
        return v;
    endfunction

    task automatic drive_a(input vec_t v);
        a_m0_rd = v.r0; a_m0_wr = v.w0; a_m0_addr = v.a0; a_m0_be = v.be0; a_m0_wd = v.d0;
        a_m1_rd = v.r1; a_m1_wr = v.w1; a_m1_addr = v.a1; a_m1_be = v.be1; a_m1_wd = v.d1;
    endtask

    task automatic drive_b(input logic r0, input logic w0, input logic [9:0] a0, input logic [31:0] d0,
                           input logic r1, input logic w1, input logic [9:0] a1, input logic [31:0] d1);
        b_m0_rd = r0; b_m0_wr = w0; b_m0_addr = a0; b_m0_be = 4'hF; b_m0_wd = d0;
        b_m1_rd = r1; b_m1_wr = w1; b_m1_addr = a1; b_m1_be = 4'hF; b_m1_wd = d1;
    endtask

    initial begin
        vec_t idle;
        idle = mk(0,0,10'h000,4'h0,32'h0, 0,0,10'h000,4'h0,32'h0, 6'b000000, 32'h0);
        drive_a(idle);
        drive_b(0,0,10'h0,32'h0, 0,0,10'h0,32'h0);

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("reset_status", {26'd0, a_m0_wait, a_m1_wait, a_m0_v, a_m1_v, a_cs, a_sw}, 32'b110000);
        check("reset_status_b", {26'd0, b_m0_wait, b_m1_wait, b_m0_v, b_m1_v, b_cs, b_sw}, 32'b110000);
        @(negedge clk);
        reset_n = 1'b1;

        // Reset asserted in the cycle a read is presented: no grant, no readdatavalid
        @(negedge clk);
        drive_a(mk(1,0,10'h005,4'hF,32'h0, 0,0,10'h000,4'h0,32'h0, 6'b0, 32'h0));
        #1;
        check("pre_reset_read_wait", {31'd0, a_m0_wait}, 32'd0);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_reset_status", {26'd0, a_m0_wait, a_m1_wait, a_m0_v, a_m1_v, a_cs, a_sw}, 32'b110000);
        @(negedge clk);
        #1;
        check("mid_reset_no_rdv", {30'd0, a_m0_v, a_m1_v}, 32'd0);
        drive_a(idle);
        reset_n = 1'b1;

        // Table: round-robin DUT, sampled 1 time unit after the falling edge
        vecs.push_back(mk(0,1,10'h005,4'hF,32'hDEADBEEF, 0,0,10'h000,4'h0,32'h0, 6'b000011, 32'h0));
        vecs.push_back(mk(1,0,10'h005,4'hF,32'h0,        0,0,10'h000,4'h0,32'h0, 6'b000010, 32'h0));
        vecs.push_back(idle);
        vecs[$].exp = 6'b001000; vecs[$].edata = 32'hDEADBEEF;
        vecs.push_back(mk(0,1,10'h010,4'hF,32'h11223344, 0,0,10'h000,4'h0,32'h0, 6'b000011, 32'h0));
        vecs.push_back(mk(0,1,10'h010,4'h2,32'h0000AA00, 0,0,10'h000,4'h0,32'h0, 6'b000011, 32'h0));
        vecs.push_back(mk(1,0,10'h010,4'hF,32'h0,        0,0,10'h000,4'h0,32'h0, 6'b000010, 32'h0));
        vecs.push_back(mk(0,0,10'h000,4'h0,32'h0,        0,1,10'h030,4'hF,32'h12345678, 6'b001011, 32'h1122AA44));
        vecs.push_back(mk(1,0,10'h005,4'hF,32'h0,        1,0,10'h030,4'hF,32'h0, 6'b010010, 32'h0));
        vecs.push_back(mk(1,0,10'h005,4'hF,32'h0,        1,0,10'h030,4'hF,32'h0, 6'b101010, 32'hDEADBEEF));
        vecs.push_back(mk(1,0,10'h005,4'hF,32'h0,        1,0,10'h030,4'hF,32'h0, 6'b010110, 32'h12345678));
        vecs.push_back(mk(1,0,10'h005,4'hF,32'h0,        1,0,10'h030,4'hF,32'h0, 6'b101010, 32'hDEADBEEF));
        vecs.push_back(mk(1,0,10'h005,4'hF,32'h0,        1,0,10'h030,4'hF,32'h0, 6'b010110, 32'h12345678));
        vecs.push_back(mk(1,0,10'h005,4'hF,32'h0,        1,0,10'h030,4'hF,32'h0, 6'b101010, 32'hDEADBEEF));
        vecs.push_back(idle);
        vecs[$].exp = 6'b000100; vecs[$].edata = 32'h12345678;
        vecs.push_back(mk(0,0,10'h000,4'h0,32'h0,        1,0,10'h3FF,4'hF,32'h0, 6'b000010, 32'h0));
        vecs.push_back(mk(0,0,10'h000,4'h0,32'h0,        1,0,10'h000,4'hF,32'h0, 6'b000110, 32'hA50003FF));
        vecs.push_back(idle);
        vecs[$].exp = 6'b000100; vecs[$].edata = 32'hA5000000;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive_a(vecs[i]);
            #1;
            check($sformatf("vec%0d_status", i),
                  {26'd0, a_m0_wait, a_m1_wait, a_m0_v, a_m1_v, a_cs, a_sw}, {26'd0, vecs[i].exp});
            if (vecs[i].exp[3]) check($sformatf("vec%0d_m0_readdata", i), a_m0_rdata, vecs[i].edata);
            if (vecs[i].exp[2]) check($sformatf("vec%0d_m1_readdata", i), a_m1_rdata, vecs[i].edata);
        end
        @(negedge clk);
        drive_a(idle);

        // Fixed priority: both masters write for 4 cycles, m0 always wins
        for (int i = 0; i < 4; i++) begin
            logic [9:0] adr;
            adr = 10'h050 + 10'(i);
            drive_b(0,1,adr,32'hA0A00000 | i, 0,1,10'h060,32'hBBBB0000);
            #1;
            check($sformatf("fixed_both_%0d_status", i), {29'd0, b_m0_wait, b_m1_wait, b_sw}, 32'b011);
            check($sformatf("fixed_both_%0d_addr", i), {22'd0, b_sram_addr}, {22'd0, adr});
            @(negedge clk);
        end
        drive_b(0,0,10'h000,32'h0, 0,1,10'h060,32'hBBBB0000);
        #1;
        check("fixed_m1_after_drop_status", {29'd0, b_m0_wait, b_m1_wait, b_sw}, 32'b001);
        check("fixed_m1_after_drop_addr", {22'd0, b_sram_addr}, 32'h060);
        @(negedge clk);
        drive_b(1,0,10'h052,32'h0, 0,0,10'h000,32'h0);
        @(negedge clk);
        drive_b(0,0,10'h000,32'h0, 1,0,10'h060,32'h0);
        #1;
        check("fixed_rd_m0_valid", {30'd0, b_m0_v, b_m1_v}, 32'b10);
        check("fixed_rd_m0_data", b_m0_rdata, 32'hA0A00002);
        @(negedge clk);
        drive_b(0,0,10'h000,32'h0, 0,0,10'h000,32'h0);
        #1;
        check("fixed_rd_m1_valid", {30'd0, b_m0_v, b_m1_v}, 32'b01);
        check("fixed_rd_m1_data", b_m1_rdata, 32'hBBBB0000);
        @(negedge clk);
        #1;
        check("fixed_idle_no_valid", {30'd0, b_m0_v, b_m1_v}, 32'b00);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
